// File: rtl/perf_pkg.sv
// perf_pkg: shared defaults and FSM encoding for the performance counter unit.
package perf_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int PC_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: up-counter with enable and synchronous clear that sticks at all-ones.
module perf_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: cycle/stall/flush counters with run limit and a valid/ready snapshot port.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             snap_req_i,
    input  logic             snap_ready_i,
    output logic             snap_valid_o,
    output logic [CNT_W-1:0] snap_cycle_o,
    output logic [CNT_W-1:0] snap_stall_o,
    output logic [CNT_W-1:0] snap_flush_o,
    output logic [PC_W-1:0]  snap_pc_o,
    output logic             done_o
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
    logic cnt_clr, run_en, hit_limit, capture;
    logic done_q, done_d, snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] snap_cycle_q, snap_cycle_d, snap_stall_q, snap_stall_d, snap_flush_q, snap_flush_d;
    logic [PC_W-1:0] snap_pc_q, snap_pc_d;

    // Equality only: a saturated counter never "becomes" the limit again.
    assign hit_limit = limit_i != '0 && cycle_cnt != '1 && cycle_cnt + CNT_W'(1) == limit_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == ST_IDLE && start_i)              ? ST_RUN  :
                  (state_q == ST_RUN && start_i && hit_limit)  ? ST_DONE : state_q;
    end

    always_comb begin
        cnt_clr = state_q == ST_IDLE;
        run_en  = state_q == ST_RUN && start_i;
        done_d  = done_q | (run_en & hit_limit);
    end

    perf_sat_counter #(.W(CNT_W)) u_cycle (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .en_i(run_en), .cnt_o(cycle_cnt)
    );
    perf_sat_counter #(.W(CNT_W)) u_stall (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr),
        .en_i(run_en & stall_i & ~jump_i & ~branch_i), .cnt_o(stall_cnt)
    );
    perf_sat_counter #(.W(CNT_W)) u_flush (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .en_i(run_en & flush_i), .cnt_o(flush_cnt)
    );

    // Capture sees the pre-increment counter values since they are the current flop outputs.
    always_comb begin
        capture      = snap_req_i && (!snap_valid_q || snap_ready_i);
        snap_valid_d = capture | (snap_valid_q & ~snap_ready_i);
        snap_cycle_d = capture ? cycle_cnt : snap_cycle_q;
        snap_stall_d = capture ? stall_cnt : snap_stall_q;
        snap_flush_d = capture ? flush_cnt : snap_flush_q;
        snap_pc_d    = capture ? pc_i      : snap_pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_cycle_q <= '0;
            snap_stall_q <= '0;
            snap_flush_q <= '0;
            snap_pc_q    <= '0;
        end else begin
            done_q       <= done_d;
            snap_valid_q <= snap_valid_d;
            snap_cycle_q <= snap_cycle_d;
            snap_stall_q <= snap_stall_d;
            snap_flush_q <= snap_flush_d;
            snap_pc_q    <= snap_pc_d;
        end
    end

    assign done_o       = done_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_cycle_o = snap_cycle_q;
    assign snap_stall_o = snap_stall_q;
    assign snap_flush_o = snap_flush_q;
    assign snap_pc_o    = snap_pc_q;
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: randomized and directed checks of perf_counter_unit against a behavioural model.
module tb_perf_counter_unit;
    localparam int CW = 16;
    localparam int PW = 32;
    localparam int MAXV = 65535;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0, flush = 1'b0;
    logic [PW-1:0] pc = '0;
    logic [CW-1:0] limit = '0;
    logic snap_req = 1'b0, snap_ready = 1'b0;
    logic snap_valid, done;
    logic [CW-1:0] s_cyc, s_stl, s_fl;
    logic [PW-1:0] s_pc;
    logic [81:0] obs;

    logic start4 = 1'b0, req4 = 1'b0, rdy4 = 1'b0;
    logic valid4, done4;
    logic [3:0] c4, st4, f4;
    logic [PW-1:0] pc4;

    int total = 0, bad = 0;
    int m_st, m_cyc, m_stl, m_fl, m_sc, m_ss, m_sf;
    bit m_done, m_sv;
    logic [PW-1:0] m_sp;

    always #5 clk = ~clk;

    perf_counter_unit dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .jump_i(jump),
        .branch_i(branch), .flush_i(flush), .pc_i(pc), .limit_i(limit),
        .snap_req_i(snap_req), .snap_ready_i(snap_ready), .snap_valid_o(snap_valid),
        .snap_cycle_o(s_cyc), .snap_stall_o(s_stl), .snap_flush_o(s_fl),
        .snap_pc_o(s_pc), .done_o(done)
    );

    perf_counter_unit #(.CNT_W(4), .PC_W(PW)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .stall_i(1'b0), .jump_i(1'b0),
        .branch_i(1'b0), .flush_i(1'b0), .pc_i('0), .limit_i(4'd0),
        .snap_req_i(req4), .snap_ready_i(rdy4), .snap_valid_o(valid4),
        .snap_cycle_o(c4), .snap_stall_o(st4), .snap_flush_o(f4),
        .snap_pc_o(pc4), .done_o(done4)
    );

    assign obs = {done, snap_valid, s_cyc, s_stl, s_fl, s_pc};

    function automatic logic [81:0] exp_vec();
        return {m_done, m_sv, 16'(m_sc), 16'(m_ss), 16'(m_sf), m_sp};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_cyc = 0; m_stl = 0; m_fl = 0;
        m_sc = 0; m_ss = 0; m_sf = 0; m_sp = '0; m_done = 0; m_sv = 0;
    endtask

    // Behaviour of one rising edge, computed from the pre-edge inputs.
    task automatic model_step();
        bit cap;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cap = snap_req && (!m_sv || snap_ready);
        m_sv = cap || (m_sv && !snap_ready);
        if (cap) begin
            m_sc = m_cyc; m_ss = m_stl; m_sf = m_fl; m_sp = pc;
        end
        if (m_st == M_IDLE) begin
            if (start) m_st = M_RUN;
        end else if (m_st == M_RUN && start) begin
            if (stall && !jump && !branch && m_stl < MAXV) m_stl++;
            if (flush && m_fl < MAXV) m_fl++;
            if (m_cyc < MAXV) begin
                m_cyc++;
                if (limit != 0 && m_cyc == int'(limit)) begin
                    m_st = M_DONE;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        start = 0; stall = 0; jump = 0; branch = 0; flush = 0;
        snap_req = 0; snap_ready = 0; start4 = 0; req4 = 0; rdy4 = 0;
        rst_n = 0;
        model_reset();
        #3;
        rst_n = 1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (obs !== 82'd0 || {valid4, done4, c4, st4, f4, pc4} !== 46'd0) begin
            bad++; $display("FAIL reset_outputs got=%h dut4=%h exp=0", obs, {valid4, done4, c4, st4, f4, pc4});
        end
        rst_n = 1;
        step();
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset_idle_edge got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_limit();
        apply_reset();
        start = 1; limit = 10; snap_req = 1; snap_ready = 1; pc = 32'h100;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL limit_vec edge%0d got=%h exp=%h", i, obs, exp_vec());
            end
            total++;
            if (done !== (i >= 10) || s_cyc !== 16'((i < 1) ? 0 : (i - 1 > 10 ? 10 : i - 1))) begin
                bad++; $display("FAIL limit_done edge%0d done=%b cyc=%0d", i, done, s_cyc);
            end
            pc += 4;
        end
    endtask

    task automatic test_stall_flush();
        logic [3:0] seq [5] = '{4'b1010, 4'b1100, 4'b1001, 4'b0001, 4'b0000};
        apply_reset();
        start = 1; limit = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            {stall, jump, branch, flush} = seq[i];
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL stall_flush_vec step%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        {stall, jump, branch, flush} = 4'b0;
        start = 0; snap_req = 1; snap_ready = 1;
        step();
        snap_req = 0;
        total++;
        if (s_stl !== 16'd1 || s_fl !== 16'd2 || s_cyc !== 16'd5) begin
            bad++; $display("FAIL stall_flush_counts stall=%0d flush=%0d cyc=%0d exp 1 2 5", s_stl, s_fl, s_cyc);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        start4 = 1;
        for (int i = 0; i < 11; i++) step();
        start4 = 0; req4 = 1; rdy4 = 1;
        step();
        req4 = 0;
        total++;
        if (c4 !== 4'd10 || valid4 !== 1'b1) begin
            bad++; $display("FAIL sat_mid cyc=%0d valid=%b exp 10 1", c4, valid4);
        end
        start4 = 1;
        for (int i = 0; i < 10; i++) step();
        start4 = 0; req4 = 1;
        step();
        req4 = 0;
        total++;
        if (c4 !== 4'd15 || done4 !== 1'b0) begin
            bad++; $display("FAIL sat_hold cyc=%0d done=%b exp 15 0", c4, done4);
        end
        rdy4 = 0;
    endtask

    task automatic test_snapshot();
        apply_reset();
        start = 1; limit = 0;
        for (int i = 0; i < 6; i++) step();
        snap_req = 1; snap_ready = 0; pc = 32'd12;
        step();
        total++;
        if (snap_valid !== 1'b1 || s_cyc !== 16'd5 || s_pc !== 32'd12 || obs !== exp_vec()) begin
            bad++; $display("FAIL snap_first valid=%b cyc=%0d pc=%0d exp 1 5 12", snap_valid, s_cyc, s_pc);
        end
        pc = 32'd99;
        step();
        total++;
        if (snap_valid !== 1'b1 || s_cyc !== 16'd5 || s_pc !== 32'd12 || obs !== exp_vec()) begin
            bad++; $display("FAIL snap_blocked valid=%b cyc=%0d pc=%0d exp 1 5 12", snap_valid, s_cyc, s_pc);
        end
        snap_req = 0; snap_ready = 1;
        step();
        total++;
        if (snap_valid !== 1'b0 || obs !== exp_vec()) begin
            bad++; $display("FAIL snap_consume valid=%b exp 0", snap_valid);
        end
        snap_req = 1; snap_ready = 0; pc = 32'd20;
        step();
        snap_ready = 1; pc = 32'd24;
        step();
        total++;
        if (snap_valid !== 1'b1 || s_cyc !== 16'd9 || s_pc !== 32'd24 || obs !== exp_vec()) begin
            bad++; $display("FAIL snap_back_to_back valid=%b cyc=%0d pc=%0d exp 1 9 24", snap_valid, s_cyc, s_pc);
        end
        snap_req = 0; snap_ready = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 50));
            for (int i = 0; i < 100; i++) begin
                start = $urandom_range(0, 9) < 8;
                {stall, jump, branch, flush} = 4'($urandom);
                snap_req = $urandom_range(0, 2) != 0;
                snap_ready = $urandom_range(0, 1) == 1;
                pc = $urandom;
                if ($urandom_range(0, 30) == 0) limit = 16'($urandom_range(0, 40));
                step();
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL random r%0d c%0d got=%h exp=%h", r, i, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1; limit = 0; snap_req = 1; snap_ready = 0; pc = 32'hABC;
        for (int i = 0; i < 8; i++) step();
        #3;
        rst_n = 0;
        model_reset();
        #1;
        total++;
        if (obs !== 82'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL async_reset got=%h exp=0", obs);
        end
        step();
        total++;
        if (obs !== 82'd0) begin
            bad++; $display("FAIL async_reset_held got=%h exp=0", obs);
        end
        #3;
        rst_n = 1; start = 0; snap_req = 1; snap_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== exp_vec() || s_cyc !== 16'd0) begin
                bad++; $display("FAIL post_reset_idle c%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        start = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL post_reset_run c%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        total++;
        if (s_cyc !== 16'd3) begin
            bad++; $display("FAIL post_reset_restart cyc=%0d exp 3", s_cyc);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_limit();
        test_stall_flush();
        test_saturation();
        test_snapshot();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
